// File: rtl/pincfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pincfg_pkg
//  Description : Shared definitions for the multi-channel pin configuration
//                block: register addresses, STATUS/CLEAR bit offsets and the
//                per-channel step FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package pincfg_pkg;

    // Register map (word addresses on the 4-bit wishbone address bus)
    localparam logic [3:0] ADDR_POLARITY  = 4'd0;
    localparam logic [3:0] ADDR_PULSE_W   = 4'd1;
    localparam logic [3:0] ADDR_DIR_SETUP = 4'd2;
    localparam logic [3:0] ADDR_CLEAR     = 4'd3;
    localparam logic [3:0] ADDR_STATUS    = 4'd4;
    localparam logic [3:0] ADDR_AUX_VAL   = 4'd5;
    localparam logic [3:0] ADDR_SAFE_VAL  = 4'd6;

    // STATUS layout; CLEAR uses the same positions for its W1C bits
    localparam int STAT_SHUTDOWN_BIT = 0;
    localparam int STAT_OVERRUN_LSB  = 8;
    localparam int STAT_BUSY_LSB     = 16;

    // Per-channel step FSM
    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_SETUP = 2'd1,
        CH_PULSE = 2'd2
    } chan_state_e;

endpackage : pincfg_pkg
`default_nettype wire

// File: rtl/stepper_pulse_chan.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_pulse_chan
//  Description : One step/dir channel. Accepts a single-cycle step request,
//                inserts a dir-to-step setup delay when the direction flips,
//                then emits a step pulse of programmable width. Requests that
//                arrive while busy are dropped and flagged as overrun.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                req_i, dir_i    - step request and its direction
//                pw_i, setup_i   - pulse width / dir setup (loaded on entry)
//                shutdown_i      - forces IDLE, masks step, ignores requests
//                clr_overrun_i   - clears the sticky overrun flag
//                step_o, dir_o   - logical step and latched direction
//                busy_o          - channel in SETUP or PULSE
//                overrun_o       - sticky dropped-request flag
//  Revision    : 1.0  initial release
// ============================================================================
module stepper_pulse_chan
    import pincfg_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic             dir_i,
    input  logic [CNT_W-1:0] pw_i,
    input  logic [CNT_W-1:0] setup_i,
    input  logic             shutdown_i,
    input  logic             clr_overrun_i,
    output logic             step_o,
    output logic             dir_o,
    output logic             busy_o,
    output logic             overrun_o
);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] pw_eff;

    // A programmed width of 0 still produces a one-cycle pulse
    always_comb begin
        pw_eff = pw_i;
        if (pw_i == '0) begin
            pw_eff[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CH_IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        // Clear first so that a same-cycle set below takes precedence
        overrun_d = overrun_q & ~clr_overrun_i;

        if (shutdown_i) begin
            // Safe state: abandon any pulse, ignore requests, hold dir
            state_d = CH_IDLE;
        end else begin
            case (state_q)
                CH_IDLE: begin
                    if (req_i) begin
                        if (dir_i != dir_q) begin
                            dir_d = dir_i;
                            if (setup_i == '0) begin
                                state_d = CH_PULSE;
                                cnt_d   = pw_eff;
                            end else begin
                                state_d = CH_SETUP;
                                cnt_d   = setup_i;
                            end
                        end else begin
                            state_d = CH_PULSE;
                            cnt_d   = pw_eff;
                        end
                    end
                end
                CH_SETUP: begin
                    if (req_i) begin
                        overrun_d = 1'b1;
                    end
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = CH_PULSE;
                        cnt_d   = pw_eff;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                CH_PULSE: begin
                    if (req_i) begin
                        overrun_d = 1'b1;
                    end
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = CH_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = CH_IDLE;
                end
            endcase
        end
    end

    // Step is masked combinationally so the pin drops in the same cycle
    // shutdown is flagged, one cycle before the FSM is forced to IDLE.
    assign step_o    = (state_q == CH_PULSE) && !shutdown_i;
    assign dir_o     = dir_q;
    assign busy_o    = (state_q != CH_IDLE);
    assign overrun_o = overrun_q;

endmodule : stepper_pulse_chan
`default_nettype wire

// File: rtl/pincfg_multi.sv
`default_nettype none
// ============================================================================
//  Module      : pincfg_multi
//  Description : Multi-channel step/dir output pin configuration. Drives
//                NUM_CH step/dir pairs plus NUM_AUX auxiliary pins through a
//                per-pin polarity register, with programmable pulse width,
//                dir setup delay, overrun detection and shutdown safe state.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                step_req, step_dir   - per-channel step request / direction
//                pins_out             - step i at [2i], dir i at [2i+1],
//                                       aux k at [2*NUM_CH+k]
//                pin_shutdown         - asynchronous shutdown request
//                wb_*                 - single-cycle wishbone register port
//  Revision    : 1.0  initial release
// ============================================================================
module pincfg_multi
    import pincfg_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int NUM_AUX = 4,
    parameter int CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           step_req,
    input  logic [NUM_CH-1:0]           step_dir,
    output logic [2*NUM_CH+NUM_AUX-1:0] pins_out,
    input  logic                        pin_shutdown,
    input  logic                        wb_stb_i,
    input  logic                        wb_cyc_i,
    input  logic                        wb_we_i,
    input  logic [3:0]                  wb_adr_i,
    input  logic [31:0]                 wb_dat_i,
    output logic [31:0]                 wb_dat_o,
    output logic                        wb_ack_o
);

    localparam int PIN_W = 2 * NUM_CH + NUM_AUX;

    logic [PIN_W-1:0]   pol_q;
    logic [CNT_W-1:0]   pw_q;
    logic [CNT_W-1:0]   setup_q;
    logic [NUM_AUX-1:0] aux_q;
    logic [NUM_AUX-1:0] safe_q;
    logic               sync1_q, sync2_q;
    logic               in_sd_q, in_sd_d;

    logic               wr_en;
    logic               clr_wr;
    logic [NUM_CH-1:0]  clr_ov;
    logic [NUM_CH-1:0]  ch_step, ch_dir, ch_busy, ch_ov;
    logic [PIN_W-1:0]   pin_logic;

    // Only some write-data bits land in registers
    logic               unused_wb_dat;
    assign unused_wb_dat = ^wb_dat_i;

    assign wr_en    = wb_cyc_i && wb_stb_i && wb_we_i;
    assign clr_wr   = wr_en && (wb_adr_i == ADDR_CLEAR);
    assign wb_ack_o = 1'b1;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pol_q   <= '0;
            pw_q    <= CNT_W'(1);
            setup_q <= '0;
            aux_q   <= '0;
            safe_q  <= '0;
        end else if (wr_en) begin
            case (wb_adr_i)
                ADDR_POLARITY:  pol_q   <= wb_dat_i[PIN_W-1:0];
                ADDR_PULSE_W:   pw_q    <= wb_dat_i[CNT_W-1:0];
                ADDR_DIR_SETUP: setup_q <= wb_dat_i[CNT_W-1:0];
                ADDR_AUX_VAL:   aux_q   <= wb_dat_i[NUM_AUX-1:0];
                ADDR_SAFE_VAL:  safe_q  <= wb_dat_i[NUM_AUX-1:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shutdown: 2-flop synchronizer feeding a sticky flag. A synchronized
    // high overrides a same-cycle clear so the flag cannot drop while the
    // shutdown input is still asserted.
    // ------------------------------------------------------------------
    assign in_sd_d = sync2_q | (in_sd_q & ~(clr_wr & wb_dat_i[STAT_SHUTDOWN_BIT]));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            in_sd_q <= 1'b0;
        end else begin
            sync1_q <= pin_shutdown;
            sync2_q <= sync1_q;
            in_sd_q <= in_sd_d;
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        assign clr_ov[gi] = clr_wr & wb_dat_i[STAT_OVERRUN_LSB + gi];

        stepper_pulse_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .req_i         (step_req[gi]),
            .dir_i         (step_dir[gi]),
            .pw_i          (pw_q),
            .setup_i       (setup_q),
            .shutdown_i    (in_sd_q),
            .clr_overrun_i (clr_ov[gi]),
            .step_o        (ch_step[gi]),
            .dir_o         (ch_dir[gi]),
            .busy_o        (ch_busy[gi]),
            .overrun_o     (ch_ov[gi])
        );
    end

    // ------------------------------------------------------------------
    // Pin mapping and polarity
    // ------------------------------------------------------------------
    always_comb begin
        pin_logic = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pin_logic[2*i]   = ch_step[i];
            pin_logic[2*i+1] = ch_dir[i];
        end
        pin_logic[2*NUM_CH +: NUM_AUX] = in_sd_q ? safe_q : aux_q;
    end

    assign pins_out = pol_q ^ pin_logic;

    // ------------------------------------------------------------------
    // Read mux (combinational from address)
    // ------------------------------------------------------------------
    always_comb begin
        wb_dat_o = '0;
        case (wb_adr_i)
            ADDR_POLARITY:  wb_dat_o[PIN_W-1:0]   = pol_q;
            ADDR_PULSE_W:   wb_dat_o[CNT_W-1:0]   = pw_q;
            ADDR_DIR_SETUP: wb_dat_o[CNT_W-1:0]   = setup_q;
            ADDR_AUX_VAL:   wb_dat_o[NUM_AUX-1:0] = aux_q;
            ADDR_SAFE_VAL:  wb_dat_o[NUM_AUX-1:0] = safe_q;
            ADDR_STATUS: begin
                wb_dat_o[STAT_SHUTDOWN_BIT] = in_sd_q;
                for (int i = 0; i < NUM_CH; i++) begin
                    wb_dat_o[STAT_OVERRUN_LSB + i] = ch_ov[i];
                    wb_dat_o[STAT_BUSY_LSB + i]    = ch_busy[i];
                end
            end
            default: ;
        endcase
    end

endmodule : pincfg_multi
`default_nettype wire

// File: tb/tb_pincfg_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pincfg_multi
//  Description : Self-checking bench for pincfg_multi. A timeline model
//                (pulse start/end cycles per channel) predicts pins_out and
//                the read data every cycle; directed literal expectations
//                are checked at chosen cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pincfg_multi;

    localparam int NUM_CH  = 2;
    localparam int NUM_AUX = 4;
    localparam int CNT_W   = 8;
    localparam int PIN_W   = 2 * NUM_CH + NUM_AUX;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_CH-1:0]  step_req;
    logic [NUM_CH-1:0]  step_dir;
    logic [PIN_W-1:0]   pins_out;
    logic               pin_shutdown;
    logic               wb_stb_i, wb_cyc_i, wb_we_i;
    logic [3:0]         wb_adr_i;
    logic [31:0]        wb_dat_i;
    logic [31:0]        wb_dat_o;
    logic               wb_ack_o;

    pincfg_multi #(
        .NUM_CH  (NUM_CH),
        .NUM_AUX (NUM_AUX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .step_req     (step_req),
        .step_dir     (step_dir),
        .pins_out     (pins_out),
        .pin_shutdown (pin_shutdown),
        .wb_stb_i     (wb_stb_i),
        .wb_cyc_i     (wb_cyc_i),
        .wb_we_i      (wb_we_i),
        .wb_adr_i     (wb_adr_i),
        .wb_dat_i     (wb_dat_i),
        .wb_dat_o     (wb_dat_o),
        .wb_ack_o     (wb_ack_o)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    // ------------------------------------------------------------------
    // Timeline model
    // ------------------------------------------------------------------
    bit               m_valid = 1'b0;
    logic [PIN_W-1:0] m_pol;
    logic [7:0]       m_pw, m_setup;
    logic [3:0]       m_aux, m_safe;
    bit               m_sd, m_p1, m_p2;
    int               m_first[NUM_CH];
    int               m_last[NUM_CH];
    int               m_busy_last[NUM_CH];
    int               m_pend[NUM_CH];
    bit               m_dir[NUM_CH];
    bit               m_ov[NUM_CH];

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_pol = '0; m_pw = 8'd1; m_setup = '0; m_aux = '0; m_safe = '0;
            m_sd = 0; m_p1 = 0; m_p2 = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_first[c] = 1; m_last[c] = 0; m_busy_last[c] = -1;
                m_pend[c] = -1; m_dir[c] = 0; m_ov[c] = 0;
            end
        end else if (m_valid) begin
            bit wr, clr;
            int pwe, su;
            wr  = wb_cyc_i && wb_stb_i && wb_we_i;
            clr = wr && (wb_adr_i == 4'd3);
            pwe = (m_pw == 0) ? 1 : int'(m_pw);
            for (int c = 0; c < NUM_CH; c++) begin
                bit set_ov;
                set_ov = 0;
                if (m_sd) begin
                    if (m_busy_last[c] > cyc) m_busy_last[c] = cyc;
                    if (m_last[c] > cyc) m_last[c] = cyc;
                    m_pend[c] = -1;
                end else begin
                    if (step_req[c]) begin
                        if (cyc <= m_busy_last[c]) begin
                            set_ov = 1;
                        end else begin
                            su = (step_dir[c] != m_dir[c]) ? int'(m_setup) : 0;
                            m_dir[c] = step_dir[c];
                            m_pend[c] = cyc + su;
                            m_busy_last[c] = m_pend[c];
                        end
                    end
                    // pulse begins after the edge that ends the setup window
                    if (m_pend[c] == cyc) begin
                        m_first[c] = cyc + 1;
                        m_last[c]  = cyc + pwe;
                        m_busy_last[c] = m_last[c];
                        m_pend[c] = -1;
                    end
                end
                m_ov[c] = set_ov | (m_ov[c] & !(clr && wb_dat_i[8+c]));
            end
            begin
                bit nsd;
                nsd  = m_p2 | (m_sd & !(clr && wb_dat_i[0]));
                m_p2 = m_p1;
                m_p1 = pin_shutdown;
                m_sd = nsd;
            end
            if (wr) begin
                case (wb_adr_i)
                    4'd0: m_pol   = wb_dat_i[PIN_W-1:0];
                    4'd1: m_pw    = wb_dat_i[7:0];
                    4'd2: m_setup = wb_dat_i[7:0];
                    4'd5: m_aux   = wb_dat_i[3:0];
                    4'd6: m_safe  = wb_dat_i[3:0];
                    default: ;
                endcase
            end
        end
        cyc++;
    end

    function automatic logic [PIN_W-1:0] model_pins();
        logic [PIN_W-1:0] l;
        l = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            l[2*c]   = (cyc >= m_first[c]) && (cyc <= m_last[c]) && !m_sd;
            l[2*c+1] = m_dir[c];
        end
        l[2*NUM_CH +: NUM_AUX] = m_sd ? m_safe : m_aux;
        return l ^ m_pol;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            4'd0: r[PIN_W-1:0] = m_pol;
            4'd1: r[7:0] = m_pw;
            4'd2: r[7:0] = m_setup;
            4'd4: begin
                r[0] = m_sd;
                for (int c = 0; c < NUM_CH; c++) begin
                    r[8+c]  = m_ov[c];
                    r[16+c] = (cyc <= m_busy_last[c]);
                end
            end
            4'd5: r[3:0] = m_aux;
            4'd6: r[3:0] = m_safe;
            default: ;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Literal expectations posted by the stimulus, checked at their cycle
    // ------------------------------------------------------------------
    typedef struct {
        int          at;
        int          kind;   // 0: pins_out, 1: wb_dat_o
        logic [31:0] mask;
        logic [31:0] val;
        string       nm;
    } lit_t;
    lit_t lq[$];

    task automatic lit(input int at, input int kind, input logic [31:0] mask,
                       input logic [31:0] val, input string nm);
        lit_t e;
        e.at = at; e.kind = kind; e.mask = mask; e.val = val; e.nm = nm;
        lq.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (m_valid) begin
            logic [PIN_W-1:0] ep;
            logic [31:0]      er, act;
            ep = model_pins();
            checks++;
            if (pins_out !== ep) begin
                errs++;
                $display("FAIL model_pins cyc=%0d got=%h exp=%h", cyc, pins_out, ep);
            end
            er = model_read(wb_adr_i);
            checks++;
            if (wb_dat_o !== er || wb_ack_o !== 1'b1) begin
                errs++;
                $display("FAIL model_rd cyc=%0d adr=%0d got=%h ack=%b exp=%h",
                         cyc, wb_adr_i, wb_dat_o, wb_ack_o, er);
            end
            for (int i = lq.size() - 1; i >= 0; i--) begin
                if (lq[i].at < cyc) begin
                    checks++; errs++;
                    $display("FAIL %s missed at cyc=%0d", lq[i].nm, lq[i].at);
                    lq.delete(i);
                end else if (lq[i].at == cyc) begin
                    act = (lq[i].kind == 0) ? 32'(pins_out) : wb_dat_o;
                    checks++;
                    if ((act & lq[i].mask) !== lq[i].val) begin
                        errs++;
                        $display("FAIL %s cyc=%0d got=%h exp=%h mask=%h",
                                 lq[i].nm, cyc, act & lq[i].mask, lq[i].val, lq[i].mask);
                    end
                    lq.delete(i);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = a; wb_dat_i = d;
        tick();
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 4'd4; wb_dat_i = '0;
    endtask

    task automatic req(input int ch, input logic d);
        step_req[ch] = 1'b1;
        step_dir[ch] = d;
        tick();
        step_req = '0;
    endtask

    int n, m;

    initial begin
        rst = 1; step_req = '0; step_dir = '0; pin_shutdown = 0;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 4'd4; wb_dat_i = '0;
        repeat (3) tick();
        rst = 0;

        // Reset state
        lit(cyc, 0, 32'hFF, 32'h0, "rst_pins");
        lit(cyc, 1, 32'hFFFF_FFFF, 32'h0, "rst_status");
        tick();
        wb_adr_i = 4'd1;
        lit(cyc, 1, 32'hFFFF_FFFF, 32'h1, "rst_pulse_w");
        tick();
        wb_adr_i = 4'd4;

        wr(4'd1, 32'd3);
        wr(4'd2, 32'd2);

        // Same direction: pulse N+1..N+3, dir untouched
        n = cyc;
        lit(n+1, 0, 32'h1, 32'h1, "a_step_on");
        lit(n+2, 0, 32'h2, 32'h0, "a_dir_hold");
        lit(n+3, 0, 32'h1, 32'h1, "a_step_last");
        lit(n+4, 0, 32'h1, 32'h0, "a_step_off");
        req(0, 1'b0);
        repeat (5) tick();

        // Direction flip with 2-cycle setup
        n = cyc;
        lit(n+1, 0, 32'h2, 32'h2, "b_dir_on");
        lit(n+2, 0, 32'h1, 32'h0, "b_setup_low");
        lit(n+3, 0, 32'h1, 32'h1, "b_step_on");
        lit(n+5, 0, 32'h1, 32'h1, "b_step_last");
        lit(n+6, 0, 32'h1, 32'h0, "b_step_off");
        req(0, 1'b1);
        repeat (6) tick();

        // Same dir again: no setup; request at N+2 is dropped
        n = cyc;
        lit(n+1, 0, 32'h1, 32'h1, "c_no_setup");
        lit(n+3, 1, 32'h100, 32'h100, "c_overrun");
        lit(n+4, 0, 32'h1, 32'h0, "c_drop_no_extend");
        req(0, 1'b1);
        tick();
        req(0, 1'b1);
        repeat (3) tick();
        wr(4'd3, 32'h100);
        lit(cyc, 1, 32'h100, 32'h0, "c_ov_clr");
        tick();

        // Channel 1, DIR_SETUP=0, back-to-back at the minimum period pw+1
        wr(4'd2, 32'd0);
        n = cyc;
        lit(n+1, 0, 32'hC, 32'hC, "d_dir_nosetup");
        lit(n+5, 0, 32'h4, 32'h4, "d_min_period");
        lit(n+6, 1, 32'h200, 32'h0, "d_no_ov");
        req(1, 1'b1);
        repeat (3) tick();
        req(1, 1'b1);
        repeat (4) tick();

        // PULSE_W=0 gives a one-cycle pulse
        wr(4'd1, 32'd0);
        n = cyc;
        lit(n+1, 0, 32'h1, 32'h1, "e_pw0_on");
        lit(n+2, 0, 32'h1, 32'h0, "e_pw0_off");
        req(0, 1'b1);
        repeat (3) tick();

        // Polarity and aux; both dirs latched at 1
        wr(4'd1, 32'd10);
        wr(4'd0, 32'h3);
        wr(4'd5, 32'hA);
        wr(4'd6, 32'h5);
        lit(cyc, 0, 32'hFF, 32'hA9, "f_idle_pol");

        // Shutdown mid-pulse
        req(0, 1'b1);
        pin_shutdown = 1'b1;
        m = cyc;
        lit(m+2, 0, 32'h1, 32'h0, "g_step_before");
        lit(m+2, 0, 32'hF0, 32'hA0, "g_aux_before");
        lit(m+3, 0, 32'h1, 32'h1, "g_step_off");
        lit(m+3, 0, 32'hF0, 32'h50, "g_aux_safe");
        lit(m+3, 1, 32'h1, 32'h1, "g_sd_status");
        repeat (4) tick();
        n = cyc;
        lit(n+1, 0, 32'h3, 32'h1, "g_req_ignored");
        lit(n+2, 1, 32'h100, 32'h0, "g_no_ov");
        req(0, 1'b0);
        repeat (2) tick();

        // Clear while shutdown input still high has no effect
        wr(4'd3, 32'h1);
        lit(cyc, 1, 32'h1, 32'h1, "h_sd_sticky");
        pin_shutdown = 1'b0;
        repeat (4) tick();
        wr(4'd3, 32'h1);
        lit(cyc, 1, 32'h1, 32'h0, "h_sd_clr");
        lit(cyc, 0, 32'hF0, 32'hA0, "h_aux_back");
        tick();

        // Reset mid-pulse
        n = cyc;
        lit(n+1, 0, 32'h1, 32'h0, "i_step_on_pol");
        lit(n+3, 0, 32'hFF, 32'h0, "i_rst_pins");
        req(0, 1'b1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule : tb_pincfg_multi
`default_nettype wire
